// File: rtl/rr_arbiter.sv
// N-way request/grant arbiter: round-robin or fixed priority, grant held
// until released by req drop, done pulse, or hold timeout while others wait.
// Ports: clock, reset (sync, active-high), req[N_REQ], done (release pulse),
//        gnt[N_REQ] one-hot, gnt_valid, gnt_id[IDW] (all registered).
module rr_arbiter #(
  parameter int N_REQ    = 4,
  parameter int RR_MODE  = 1,
  parameter int MAX_HOLD = 8,
  localparam int IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic [N_REQ-1:0] gnt,
  output logic             gnt_valid,
  output logic [IDW-1:0]   gnt_id
);

  localparam int HW = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  state_t           state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic             gnt_valid_q, gnt_valid_d;
  logic [IDW-1:0]   gnt_id_q, gnt_id_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [HW-1:0]    hold_q, hold_d;

  logic             rel_ab;
  logic             rel_c;
  logic             others;
  logic             arb;
  logic [N_REQ-1:0] cand;
  logic [IDW-1:0]   win;

  // First set candidate scanning up from p (wrapping), or from 0 in
  // fixed-priority mode.
  function automatic logic [IDW-1:0] pick(
    input logic [N_REQ-1:0] c,
    input logic [IDW-1:0]   p
  );
    logic [IDW-1:0] w;
    logic           hit;
    int             k;
    w   = '0;
    hit = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      k = (RR_MODE != 0) ? int'(p) + i : i;
      if (k >= N_REQ) k = k - N_REQ;
      if (!hit && c[k]) begin
        hit = 1'b1;
        w   = IDW'(k);
      end
    end
    return w;
  endfunction

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    gnt_valid_d = gnt_valid_q;
    gnt_id_d    = gnt_id_q;
    ptr_d       = ptr_q;
    hold_d      = hold_q;

    others = |(req & ~gnt_q);
    rel_ab = ~req[gnt_id_q] | done;
    // Timeout only forces a hand-over when someone else is waiting.
    rel_c  = (MAX_HOLD != 0) &&
             (hold_q == HW'(MAX_HOLD)) && others;
    // On timeout the owner is excluded; otherwise it may win again.
    cand   = rel_ab ? req : (req & ~gnt_q);
    arb    = 1'b0;

    unique case (state_q)
      IDLE: begin
        cand = req;
        arb  = |req;
      end
      GRANT: begin
        if (rel_ab || rel_c) begin
          if (|cand) begin
            arb = 1'b1;
          end else begin
            state_d     = IDLE;
            gnt_d       = '0;
            gnt_valid_d = 1'b0;
            gnt_id_d    = '0;
            hold_d      = '0;
          end
        end else if (MAX_HOLD != 0 &&
                     hold_q != HW'(MAX_HOLD)) begin
          hold_d = hold_q + HW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    win = pick(cand, ptr_q);

    if (arb) begin
      state_d     = GRANT;
      gnt_d       = '0;
      gnt_d[win]  = 1'b1;
      gnt_valid_d = 1'b1;
      gnt_id_d    = win;
      hold_d      = HW'(1);
      if (RR_MODE != 0) begin
        ptr_d = (int'(win) == N_REQ - 1) ? '0 : win + IDW'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      gnt_valid_q <= 1'b0;
      gnt_id_q    <= '0;
      ptr_q       <= '0;
      hold_q      <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      gnt_valid_q <= gnt_valid_d;
      gnt_id_q    <= gnt_id_d;
      ptr_q       <= ptr_d;
      hold_q      <= hold_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_valid = gnt_valid_q;
  assign gnt_id    = gnt_id_q;

endmodule

// File: tb/tb_rr_arbiter.sv
// Bench for rr_arbiter: a round-robin and a fixed-priority instance run
// side by side against a cycle-level reference model.
module tb_rr_arbiter;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] req;
  logic       done;

  logic [3:0] gnt_rr, gnt_fx;
  logic       vld_rr, vld_fx;
  logic [1:0] id_rr, id_fx;

  int checks = 0;
  int errors = 0;

  // Model state per instance: 0 = round-robin, 1 = fixed priority.
  int owner[2];
  int ptr[2];
  int hold[2];
  int n_owner[2];
  int n_ptr[2];
  int n_hold[2];
  int rrm[2] = '{1, 0};

  always #5 clock = ~clock;

  rr_arbiter #(.N_REQ(4), .RR_MODE(1), .MAX_HOLD(8)) u_rr (
    .clock(clock), .reset(reset), .req(req), .done(done),
    .gnt(gnt_rr), .gnt_valid(vld_rr), .gnt_id(id_rr)
  );

  rr_arbiter #(.N_REQ(4), .RR_MODE(0), .MAX_HOLD(8)) u_fx (
    .clock(clock), .reset(reset), .req(req), .done(done),
    .gnt(gnt_fx), .gnt_valid(vld_fx), .gnt_id(id_fx)
  );

  function automatic int winner(int m, logic [3:0] c);
    int i;
    for (int off = 0; off < 4; off++) begin
      i = rrm[m] ? (ptr[m] + off) % 4 : off;
      if (c[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_next(int m);
    logic [3:0] c;
    logic       rel;
    logic       others;
    int         w;
    n_owner[m] = owner[m];
    n_ptr[m]   = ptr[m];
    n_hold[m]  = hold[m];
    c = 4'b0000;
    w = -1;
    if (reset) begin
      n_owner[m] = -1;
      n_ptr[m]   = 0;
      n_hold[m]  = 0;
      return;
    end
    if (owner[m] < 0) begin
      c   = req;
      rel = 1'b1;
    end else begin
      others = (req & ~(4'b0001 << owner[m])) != 4'b0000;
      if (!req[owner[m]] || done) begin
        rel = 1'b1;
        c   = req;
      end else if (hold[m] == 8 && others) begin
        rel = 1'b1;
        c   = req & ~(4'b0001 << owner[m]);
      end else begin
        rel = 1'b0;
        n_hold[m] = (hold[m] < 8) ? hold[m] + 1 : 8;
      end
    end
    if (rel) begin
      w = winner(m, c);
      n_owner[m] = w;
      n_hold[m]  = (w < 0) ? 0 : 1;
      if (w >= 0 && rrm[m] != 0) n_ptr[m] = (w + 1) % 4;
    end
  endtask

  task automatic chk(string tag, logic [3:0] og, logic ov,
                     logic [1:0] oi, int m);
    logic [3:0] eg;
    logic       ev;
    logic [1:0] ei;
    eg = (owner[m] < 0) ? 4'b0000 : 4'b0001 << owner[m];
    ev = owner[m] >= 0;
    ei = (owner[m] < 0) ? 2'd0 : 2'(owner[m]);
    checks++;
    assert (og === eg) else begin
      errors++;
      $error("FAIL %s gnt obs=%b exp=%b t=%0t", tag, og, eg, $time);
    end
    checks++;
    assert (ov === ev) else begin
      errors++;
      $error("FAIL %s gnt_valid obs=%b exp=%b t=%0t", tag, ov, ev, $time);
    end
    checks++;
    assert (oi === ei) else begin
      errors++;
      $error("FAIL %s gnt_id obs=%0d exp=%0d t=%0t", tag, oi, ei, $time);
    end
  endtask

  task automatic step();
    model_next(0);
    model_next(1);
    @(posedge clock);
    #1;
    for (int m = 0; m < 2; m++) begin
      owner[m] = n_owner[m];
      ptr[m]   = n_ptr[m];
      hold[m]  = n_hold[m];
    end
    chk("rr", gnt_rr, vld_rr, id_rr, 0);
    chk("fx", gnt_fx, vld_fx, id_fx, 1);
  endtask

  task automatic chk_const(string tag, logic [3:0] obs, logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%b exp=%b t=%0t", tag, obs, exp, $time);
    end
  endtask

  initial begin
    for (int m = 0; m < 2; m++) begin
      owner[m] = -1;
      ptr[m]   = 0;
      hold[m]  = 0;
    end
    reset = 1'b1;
    req   = 4'b1111;
    done  = 1'b0;

    // Reset with all requesting, then release.
    step();
    step();
    chk_const("reset_gnt", gnt_rr, 4'b0000);
    reset = 1'b0;
    step();
    chk_const("first_gnt", gnt_rr, 4'b0001);

    // Round-robin rotation with done every third cycle.
    for (int i = 0; i < 14; i++) begin
      done = (i % 3 == 2);
      step();
    end
    done = 1'b0;

    // Timeout: two requesters, no done.
    reset = 1'b1;
    step();
    reset = 1'b0;
    req   = 4'b0011;
    step();
    chk_const("to_first", gnt_rr, 4'b0001);
    for (int i = 0; i < 7; i++) step();
    chk_const("to_hold8", gnt_rr, 4'b0001);
    step();
    chk_const("to_switch", gnt_rr, 4'b0010);
    for (int i = 0; i < 10; i++) step();

    // Lone requester holds indefinitely.
    req = 4'b0001;
    for (int i = 0; i < 20; i++) step();
    chk_const("lone_hold", gnt_rr, 4'b0001);

    // Fixed-priority pattern with done pulses, then drop req[1].
    req = 4'b1010;
    for (int i = 0; i < 8; i++) begin
      done = (i % 2 == 1);
      step();
    end
    done = 1'b0;
    chk_const("fx_keep", gnt_fx, 4'b0010);
    req = 4'b1000;
    step();
    chk_const("fx_drop", gnt_fx, 4'b1000);

    // Drop to idle, then a late requester.
    req = 4'b0000;
    step();
    step();
    req = 4'b0100;
    step();
    chk_const("idle_wake", gnt_rr, 4'b0100);
    step();

    // Reset mid-grant, release with 1100.
    reset = 1'b1;
    step();
    chk_const("mid_reset", gnt_rr, 4'b0000);
    reset = 1'b0;
    req   = 4'b1100;
    step();
    chk_const("post_reset", gnt_rr, 4'b0100);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 4) == 0) req = 4'($urandom);
      done  = ($urandom_range(0, 3) == 0);
      reset = ($urandom_range(0, 79) == 0);
      step();
    end
    reset = 1'b0;
    done  = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
